// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the pipelined core.
//   XLEN / INSTR_W : datapath and instruction widths
//   PC_INC         : sequential PC step (one 32-bit word)
//   NOP_INSTR      : canonical no-op (addi x0, x0, 0)
//   fetch_state_e  : instruction fetch FSM states
//   align_pc()     : force a PC onto a word boundary
package cpu_pkg;

  localparam int XLEN    = 32;
  localparam int INSTR_W = 32;

  localparam logic [XLEN-1:0]    PC_INC    = 32'd4;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } fetch_state_e;

  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    align_pc = {pc[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: small synchronous FIFO, DEPTH entries of WIDTH bits.
//   clk, rst     : clock, asynchronous active-high reset
//   push_i       : write push_data_i at the tail (ignored when full)
//   pop_i        : drop the head entry (ignored when empty)
//   flush_i      : discard all entries; wins over push/pop in the same cycle
//   head_o       : oldest entry, valid while !empty_o
//   count_o      : number of stored entries
//   full_o       : count_o == DEPTH
//   empty_o      : count_o == 0
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [WIDTH-1:0] head_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) ptr_inc = '0;
    else                        ptr_inc = p + 1'b1;
  endfunction

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o && !flush_i;
  assign do_pop  = pop_i && !empty_o && !flush_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  // The fetch credit scheme makes a push into a full FIFO impossible.
  a_no_push_when_full: assert property (
    @(posedge clk) disable iff (rst) !(push_i && !flush_i && full_o)
  );

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: instruction fetch stage feeding the IF/ID register.
// Owns the PC, issues in-order word reads, buffers returned words with
// their PCs and presents one {pc, instr} pair per cycle.  A redirect
// flushes the buffer and discards every response still in flight.
//   clk, rst                   : clock, asynchronous active-high reset
//   imem_req_valid/addr/ready  : read request handshake (transfer when
//                                valid && ready in the same cycle)
//   imem_rsp_valid/data        : in-order read responses
//   redirect_valid/pc          : flush and restart fetch at redirect_pc
//   stall                      : downstream holds the presented pair
//   if_valid/if_pc/if_instr    : pair presented to IF/ID
//   dbg_state/dbg_outstanding  : FSM state and in-flight request count
module instr_fetch
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2,
  localparam int         CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req_valid,
  output logic [XLEN-1:0]    imem_req_addr,
  input  logic               imem_req_ready,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  input  logic               redirect_valid,
  input  logic [XLEN-1:0]    redirect_pc,
  input  logic               stall,
  output logic               if_valid,
  output logic [XLEN-1:0]    if_pc,
  output logic [INSTR_W-1:0] if_instr,
  output fetch_state_e       dbg_state,
  output logic [CNT_W-1:0]   dbg_outstanding
);

  fetch_state_e       state_q, state_d;
  logic [XLEN-1:0]    fetch_pc_q, fetch_pc_d;
  logic [CNT_W-1:0]   outstanding_q, outstanding_d;
  logic [CNT_W-1:0]   kill_q, kill_d;
  logic [CNT_W-1:0]   remaining;
  logic [XLEN-1:0]    last_pc_q;
  logic [INSTR_W-1:0] last_instr_q;

  logic                       buf_push, buf_pop, buf_flush;
  logic [XLEN+INSTR_W-1:0]    buf_head;
  logic [CNT_W-1:0]           buf_count;
  logic                       buf_full, buf_empty;

  logic               pcq_push, pcq_pop, pcq_flush;
  logic [XLEN-1:0]    pcq_head;
  logic [CNT_W-1:0]   pcq_count;
  logic               pcq_full, pcq_empty;

  logic               run;
  logic               pop_now;
  logic               accept;
  logic [CNT_W:0]     credit_used;
  logic               unused_fifo_status;

  fetch_fifo #(.DEPTH(DEPTH), .WIDTH(XLEN + INSTR_W)) u_buf (
    .clk         (clk),
    .rst         (rst),
    .push_i      (buf_push),
    .push_data_i ({pcq_head, imem_rsp_data}),
    .pop_i       (buf_pop),
    .flush_i     (buf_flush),
    .head_o      (buf_head),
    .count_o     (buf_count),
    .full_o      (buf_full),
    .empty_o     (buf_empty)
  );

  // Addresses of accepted requests, matched to responses in order.
  fetch_fifo #(.DEPTH(DEPTH), .WIDTH(XLEN)) u_pcq (
    .clk         (clk),
    .rst         (rst),
    .push_i      (pcq_push),
    .push_data_i (fetch_pc_q),
    .pop_i       (pcq_pop),
    .flush_i     (pcq_flush),
    .head_o      (pcq_head),
    .count_o     (pcq_count),
    .full_o      (pcq_full),
    .empty_o     (pcq_empty)
  );

  assign unused_fifo_status = ^{pcq_count, pcq_full, pcq_empty, buf_full};

  assign run      = (state_q == ST_RUN);
  assign if_valid = run && !buf_empty;
  // A redirect squashes the pop: the pair is gone with the flushed buffer.
  assign pop_now  = if_valid && !stall && !redirect_valid;

  // Requests in flight plus buffered entries never exceed DEPTH.  The slot
  // freed by this cycle's pop counts as free, which sustains one
  // instruction per cycle with DEPTH=2 and single-cycle memory.
  assign credit_used    = {1'b0, outstanding_q} + {1'b0, buf_count}
                        - {{CNT_W{1'b0}}, pop_now};
  assign imem_req_valid = run && !redirect_valid
                        && (credit_used < (CNT_W + 1)'(DEPTH));
  assign imem_req_addr  = fetch_pc_q;
  assign accept         = imem_req_valid && imem_req_ready;

  // When the buffer is empty the last consumed pair stays on the outputs.
  assign if_pc    = buf_empty ? last_pc_q    : buf_head[XLEN+INSTR_W-1:INSTR_W];
  assign if_instr = buf_empty ? last_instr_q : buf_head[INSTR_W-1:0];

  assign dbg_state       = state_q;
  assign dbg_outstanding = outstanding_q;

  // Responses still owed after a redirect; one arriving now is dropped.
  assign remaining = outstanding_q - CNT_W'(imem_rsp_valid);

  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    outstanding_d = outstanding_q;
    kill_d        = kill_q;
    buf_push      = 1'b0;
    buf_pop       = 1'b0;
    buf_flush     = 1'b0;
    pcq_push      = 1'b0;
    pcq_pop       = 1'b0;
    pcq_flush     = 1'b0;

    unique case (state_q)
      ST_BOOT: begin
        state_d = ST_RUN;
      end
      ST_RUN, ST_FLUSH: begin
        if (redirect_valid) begin
          buf_flush     = 1'b1;
          pcq_flush     = 1'b1;
          fetch_pc_d    = align_pc(redirect_pc);
          outstanding_d = remaining;
          kill_d        = remaining;
          state_d       = (remaining != '0) ? ST_FLUSH : ST_RUN;
        end else if (state_q == ST_RUN) begin
          outstanding_d = outstanding_q + CNT_W'(accept) - CNT_W'(imem_rsp_valid);
          pcq_push      = accept;
          pcq_pop       = imem_rsp_valid;
          buf_push      = imem_rsp_valid;
          buf_pop       = pop_now;
          if (accept) fetch_pc_d = fetch_pc_q + PC_INC;
        end else begin
          outstanding_d = remaining;
          kill_d        = kill_q - CNT_W'(imem_rsp_valid);
          if (kill_d == '0) state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_BOOT;
      fetch_pc_q    <= RESET_PC;
      outstanding_q <= '0;
      kill_q        <= '0;
      last_pc_q     <= '0;
      last_instr_q  <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      outstanding_q <= outstanding_d;
      kill_q        <= kill_d;
      if (buf_pop) begin
        last_pc_q    <= buf_head[XLEN+INSTR_W-1:INSTR_W];
        last_instr_q <= buf_head[INSTR_W-1:0];
      end
    end
  end

  a_outstanding_bound: assert property (
    @(posedge clk) disable iff (rst) outstanding_q <= CNT_W'(DEPTH)
  );

endmodule

// File: tb/tb_instr_fetch.sv
// Testbench for instr_fetch: directed timing scenarios with literal
// expectations plus a randomized phase, all checked every cycle against a
// PC-stream reference model and an in-order memory model.
module tb_instr_fetch;
  import cpu_pkg::*;

  localparam int          DEPTH    = 2;
  localparam int          CNT_W    = $clog2(DEPTH + 1);
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic             imem_req_valid;
  logic [31:0]      imem_req_addr;
  logic             imem_req_ready = 1'b1;
  logic             imem_rsp_valid = 1'b0;
  logic [31:0]      imem_rsp_data  = '0;
  logic             redirect_valid = 1'b0;
  logic [31:0]      redirect_pc    = '0;
  logic             stall          = 1'b0;
  logic             if_valid;
  logic [31:0]      if_pc;
  logic [31:0]      if_instr;
  fetch_state_e     dbg_state;
  logic [CNT_W-1:0] dbg_outstanding;

  instr_fetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req_valid  (imem_req_valid),
    .imem_req_addr   (imem_req_addr),
    .imem_req_ready  (imem_req_ready),
    .imem_rsp_valid  (imem_rsp_valid),
    .imem_rsp_data   (imem_rsp_data),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .stall           (stall),
    .if_valid        (if_valid),
    .if_pc           (if_pc),
    .if_instr        (if_instr),
    .dbg_state       (dbg_state),
    .dbg_outstanding (dbg_outstanding)
  );

  // ---------------- check bookkeeping ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory contents: each word is a fixed function of its address.
  function automatic logic [31:0] instr_of(input logic [31:0] a);
    instr_of = a ^ 32'h5A5A_0000;
  endfunction

  // ---------------- memory model ----------------
  typedef struct {
    int          due;
    logic [31:0] addr;
  } mem_t;

  mem_t mem_q[$];
  int   cyc      = 0;
  int   last_due = 0;
  int   lat_min  = 1;
  int   lat_max  = 1;

  always begin
    @(posedge clk);
    cyc = cyc + 1;
    #1;
    if (!rst && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = instr_of(mem_q[0].addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
  end

  // ---------------- scoreboard / reference model ----------------
  // exp_q holds the PCs of the current path, in the order they must be
  // presented; exp_fetch is the next address that must be requested.
  logic [31:0] exp_q[$];
  logic [31:0] exp_fetch = RESET_PC;
  int          due_c;
  mem_t        ent;

  always @(negedge clk) begin
    if (rst) begin
      mem_q.delete();
      exp_q.delete();
      exp_fetch = RESET_PC;
      last_due  = 0;
    end else begin
      chk("outstanding_dbg", 32'(dbg_outstanding), 32'(mem_q.size()));
      chk("outstanding_bound", 32'(mem_q.size() <= DEPTH), 32'd1);
      if (redirect_valid) chk("req_in_redirect", 32'(imem_req_valid), 32'd0);
      if (imem_req_valid) chk("req_addr", imem_req_addr, exp_fetch);
      if (if_valid) begin
        if (exp_q.size() == 0) chk("if_valid_unexpected", 32'd1, 32'd0);
        else begin
          chk("if_pc", if_pc, exp_q[0]);
          chk("if_instr", if_instr, instr_of(exp_q[0]));
        end
      end

      if (redirect_valid) begin
        exp_q.delete();
        exp_fetch = {redirect_pc[31:2], 2'b00};
      end else begin
        if (imem_req_valid && imem_req_ready) begin
          exp_q.push_back(exp_fetch);
          exp_fetch = exp_fetch + 32'd4;
        end
        if (if_valid && !stall && exp_q.size() > 0) void'(exp_q.pop_front());
      end
      chk("path_credit", 32'(exp_q.size() <= DEPTH), 32'd1);

      if (imem_rsp_valid && mem_q.size() > 0) void'(mem_q.pop_front());
      if (imem_req_valid && imem_req_ready) begin
        due_c = cyc + int'($urandom_range(lat_min, lat_max));
        if (due_c <= last_due) due_c = last_due + 1;
        last_due = due_c;
        ent.due  = due_c;
        ent.addr = imem_req_addr;
        mem_q.push_back(ent);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // One cycle with the given inputs; returns at the falling edge.
  task automatic cyc_in(input logic st, input logic rd, input logic [31:0] rpc,
                        input logic rdy);
    @(posedge clk);
    #1;
    stall          = st;
    redirect_valid = rd;
    redirect_pc    = rpc;
    imem_req_ready = rdy;
    @(negedge clk);
  endtask

  task automatic idle();
    cyc_in(1'b0, 1'b0, 32'h0, 1'b1);
  endtask

  // Pulse reset, check reset values, release; returns in the BOOT cycle.
  task automatic do_reset();
    @(posedge clk);
    #1;
    rst            = 1'b1;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    imem_req_ready = 1'b1;
    @(negedge clk);
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_req_addr", imem_req_addr, RESET_PC);
    chk("rst_if_valid", 32'(if_valid), 32'd0);
    chk("rst_if_pc", if_pc, 32'h0);
    chk("rst_if_instr", if_instr, 32'h0);
    chk("rst_state", 32'(dbg_state), 32'(ST_BOOT));
    chk("rst_outstanding", 32'(dbg_outstanding), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("boot_state", 32'(dbg_state), 32'(ST_BOOT));
    chk("boot_no_req", 32'(imem_req_valid), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  int n;

  initial begin
    // Zero-wait memory: requests 0,4,8.. and a gapless stream from cycle 3.
    lat_min = 1; lat_max = 1;
    do_reset();
    idle();
    chk("t1_c1_req", 32'(imem_req_valid), 32'd1);
    chk("t1_c1_addr", imem_req_addr, 32'h0);
    chk("t1_c1_ifv", 32'(if_valid), 32'd0);
    idle();
    chk("t1_c2_addr", imem_req_addr, 32'h4);
    chk("t1_c2_ifv", 32'(if_valid), 32'd0);
    for (int i = 0; i < 5; i++) begin
      idle();
      chk("t1_stream_ifv", 32'(if_valid), 32'd1);
      chk("t1_stream_pc", if_pc, 32'(4 * i));
    end

    // Stall for 5 cycles: presented pair frozen, nothing lost afterwards.
    for (int i = 0; i < 5; i++) begin
      cyc_in(1'b1, 1'b0, 32'h0, 1'b1);
      chk("t2_stall_pc", if_pc, 32'h14);
      chk("t2_stall_ifv", 32'(if_valid), 32'd1);
    end
    idle();
    chk("t2_release_pc0", if_pc, 32'h14);
    idle();
    chk("t2_release_pc1", if_pc, 32'h18);
    chk("t2_release_ifv", 32'(if_valid), 32'd1);

    // Redirect with two requests in flight (4-cycle memory).
    lat_min = 4; lat_max = 4;
    do_reset();
    idle();
    chk("t3_c1_addr", imem_req_addr, 32'h0);
    idle();
    chk("t3_c2_addr", imem_req_addr, 32'h4);
    chk("t3_c2_req", 32'(imem_req_valid), 32'd1);
    cyc_in(1'b0, 1'b1, 32'h100, 1'b1);
    chk("t3_redirect_noreq", 32'(imem_req_valid), 32'd0);
    chk("t3_two_inflight", 32'(dbg_outstanding), 32'd2);
    for (int i = 0; i < 3; i++) begin
      idle();
      chk("t3_flush_state", 32'(dbg_state), 32'(ST_FLUSH));
      chk("t3_flush_ifv", 32'(if_valid), 32'd0);
      chk("t3_flush_noreq", 32'(imem_req_valid), 32'd0);
    end
    idle();
    chk("t3_run_state", 32'(dbg_state), 32'(ST_RUN));
    chk("t3_new_addr", imem_req_addr, 32'h100);
    chk("t3_new_req", 32'(imem_req_valid), 32'd1);
    n = 0;
    do begin
      idle();
      n++;
    end while (!if_valid && n < 10);
    chk("t3_latency", 32'(n), 32'd5);
    chk("t3_first_pc", if_pc, 32'h100);
    chk("t3_first_instr", if_instr, 32'h5A5A_0100);

    // Redirect coincident with a response and a would-be pop.
    lat_min = 1; lat_max = 1;
    do_reset();
    for (int i = 0; i < 4; i++) idle();
    cyc_in(1'b0, 1'b1, 32'h200, 1'b1);
    chk("t4_presented", if_pc, 32'h8);
    chk("t4_outstanding", 32'(dbg_outstanding), 32'd1);
    idle();
    chk("t4_no_kill_state", 32'(dbg_state), 32'(ST_RUN));
    chk("t4_new_addr", imem_req_addr, 32'h200);
    chk("t4_c6_ifv", 32'(if_valid), 32'd0);
    idle();
    chk("t4_c7_ifv", 32'(if_valid), 32'd0);
    idle();
    chk("t4_first_ifv", 32'(if_valid), 32'd1);
    chk("t4_first_pc", if_pc, 32'h200);

    // Misaligned redirect near the top of memory: wraps to 0.
    cyc_in(1'b0, 1'b1, 32'hFFFF_FFFE, 1'b1);
    idle();
    chk("t5_req_top", imem_req_addr, 32'hFFFF_FFFC);
    chk("t5_req_valid", 32'(imem_req_valid), 32'd1);
    idle();
    chk("t5_req_wrap", imem_req_addr, 32'h0);
    idle();
    chk("t5_pc_top", if_pc, 32'hFFFF_FFFC);
    chk("t5_instr_top", if_instr, 32'hA5A5_FFFC);
    idle();
    chk("t5_pc_wrap", if_pc, 32'h0);
    idle();
    chk("t5_pc_after", if_pc, 32'h4);

    // Random memory latency, ready, stalls and redirects.
    lat_min = 1; lat_max = 6;
    for (int i = 0; i < 3000; i++) begin
      logic        st, rd, rdy;
      logic [31:0] rpc;
      st  = ($urandom_range(0, 99) < 25);
      rdy = ($urandom_range(0, 99) < 70);
      rd  = ($urandom_range(0, 99) < 3);
      rpc = $urandom();
      if ($urandom_range(0, 3) == 0) rpc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      cyc_in(st, rd, rpc, rdy);
    end
    for (int i = 0; i < 20; i++) idle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d",
             n_errors, n_checks);
    $fatal(1);
  end

endmodule
